// File: rtl/msrv32_pkg.sv
// Shared RV32 writeback definitions: register-file geometry and WB mux select encodings.
package msrv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Writeback source select, common to the WB mux and the register file
  typedef enum logic [2:0] {
    WB_ALU        = 3'b000,
    WB_LU         = 3'b001,
    WB_IMM        = 3'b010,
    WB_IADDER_OUT = 3'b011,
    WB_CSR        = 3'b100,
    WB_PC_PLUS    = 3'b101
  } wb_sel_e;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One combinational register-file read port: x0 zeroing, reset gating and,
// with MSRV32_RF_BYPASS_EN defined, a write-first bypass from the writeback data.
module msrv32_rf_read_port
  import msrv32_pkg::*;
#(
  parameter int unsigned DATA_W = msrv32_pkg::XLEN,
  parameter int unsigned DEPTH  = msrv32_pkg::NREGS
) (
  input  logic                  rst_in,
  input  logic                  commit_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [DATA_W-1:0]     rd_in,
  input  logic [DATA_W-1:0]     regs_in [DEPTH],
  input  logic [REG_ADDR_W-1:0] rs_addr_in,
  output logic [DATA_W-1:0]     rs_out
);

`ifdef MSRV32_RF_BYPASS_EN
  always_comb begin
    rs_out = '0;
    if (!rst_in && (rs_addr_in != '0)) begin
      if (commit_in && (rs_addr_in == rd_addr_in)) begin
        rs_out = rd_in;
      end else begin
        rs_out = regs_in[rs_addr_in];
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{commit_in, rd_addr_in, rd_in};

  always_comb begin
    rs_out = '0;
    if (!rst_in && (rs_addr_in != '0)) begin
      rs_out = regs_in[rs_addr_in];
    end
  end
`endif

endmodule

// File: rtl/msrv32_wb_reg_file.sv
// 32x32 integer register file with committed-write counter.
// Optional same-cycle bypass is enabled by defining MSRV32_RF_BYPASS_EN.
module msrv32_wb_reg_file
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN  = msrv32_pkg::XLEN,
  parameter int unsigned NREGS = msrv32_pkg::NREGS,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en_in,
  input  logic                  flush_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [XLEN-1:0]       rd_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out,
  output logic [CNT_W-1:0]      wr_count_out
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             commit;

  assign commit = wr_en_in & ~flush_in & ~rst_in & (rd_addr_in != '0);
  assign cnt_d  = cnt_q + CNT_W'(1);

  // Reset wins over a concurrent write; the counter wraps naturally.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (commit) begin
      regs_q[rd_addr_in] <= rd_in;
      cnt_q              <= cnt_d;
    end
  end

  assign wr_count_out = cnt_q;

  msrv32_rf_read_port #(
    .DATA_W (XLEN),
    .DEPTH  (NREGS)
  ) u_rd_port_1 (
    .rst_in     (rst_in),
    .commit_in  (commit),
    .rd_addr_in (rd_addr_in),
    .rd_in      (rd_in),
    .regs_in    (regs_q),
    .rs_addr_in (rs_1_addr_in),
    .rs_out     (rs_1_out)
  );

  msrv32_rf_read_port #(
    .DATA_W (XLEN),
    .DEPTH  (NREGS)
  ) u_rd_port_2 (
    .rst_in     (rst_in),
    .commit_in  (commit),
    .rd_addr_in (rd_addr_in),
    .rd_in      (rd_in),
    .regs_in    (regs_q),
    .rs_addr_in (rs_2_addr_in),
    .rs_out     (rs_2_out)
  );

endmodule

// File: tb/tb_msrv32_wb_reg_file.sv
// Self-checking bench for msrv32_wb_reg_file: directed steps then random traffic
// against an array-based reference model; a narrow-counter instance checks wrap.
module tb_msrv32_wb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        fl;
  logic [4:0]  rd_a;
  logic [31:0] rd_d;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] cnt;
  logic [31:0] rs1_w;
  logic [31:0] rs2_w;
  logic [3:0]  cnt_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  msrv32_wb_reg_file dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .wr_en_in     (we),
    .flush_in     (fl),
    .rd_addr_in   (rd_a),
    .rd_in        (rd_d),
    .rs_1_addr_in (a1),
    .rs_2_addr_in (a2),
    .rs_1_out     (rs1),
    .rs_2_out     (rs2),
    .wr_count_out (cnt)
  );

  msrv32_wb_reg_file #(.CNT_W(4)) dut_w (
    .clk_in       (clk),
    .rst_in       (rst),
    .wr_en_in     (we),
    .flush_in     (fl),
    .rd_addr_in   (rd_a),
    .rd_in        (rd_d),
    .rs_1_addr_in (a1),
    .rs_2_addr_in (a2),
    .rs_1_out     (rs1_w),
    .rs_2_out     (rs2_w),
    .wr_count_out (cnt_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_commit();
    return we && !fl && !rst && (rd_a != 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
`ifdef MSRV32_RF_BYPASS_EN
    if (model_commit() && a == rd_a) return rd_d;
`endif
    return m_regs[a];
  endfunction

  // Drive one cycle, check reads mid-cycle, advance model at the edge, check count.
  task automatic cyc(input logic r, input logic w, input logic f, input logic [4:0] d_a,
                     input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst = r; we = w; fl = f; rd_a = d_a; rd_d = d; a1 = r1; a2 = r2;
    #1;
    chk("rs1", rs1, model_read(r1));
    chk("rs2", rs2, model_read(r2));
    chk("rs1_w", rs1_w, model_read(r1));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
    end else if (model_commit()) begin
      m_regs[rd_a] = rd_d;
      m_cnt = m_cnt + 32'd1;
    end
    #1;
    chk("count", cnt, m_cnt);
    chk("count_wrap4", {28'h0, cnt_w}, {28'h0, m_cnt[3:0]});
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; fl = 1'b0; rd_a = '0; rd_d = '0; a1 = '0; a2 = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;

    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    // preload x5 then reset twice with a write in flight to x4
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4);
    chk("preload_x5", rs1, 32'hDEADBEEF);
    cyc(1'b1, 1'b1, 1'b0, 5'd4, 32'hCAFEF00D, 5'd5, 5'd4);
    cyc(1'b1, 1'b1, 1'b0, 5'd4, 32'hCAFEF00D, 5'd5, 5'd4);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
    chk("reset_x5", rs1, 32'h0);
    chk("reset_x4", rs2, 32'h0);
    chk("reset_count", cnt, 32'h0);

    cyc(1'b0, 1'b1, 1'b0, 5'd3, 32'h12345678, 5'd0, 5'd3);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    chk("basic_x3", rs2, 32'h12345678);
    chk("basic_count", cnt, 32'd1);

    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("x0_count", cnt, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("x0_read", rs1, 32'h0);

    cyc(1'b0, 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("flush_x7", rs1, 32'h0);
    chk("flush_count", cnt, 32'd1);

    cyc(1'b0, 1'b1, 1'b0, 5'd9, 32'h11, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0; we = 1'b1; fl = 1'b0; rd_a = 5'd9; rd_d = 32'h22; a1 = 5'd9; a2 = 5'd9;
    #1;
`ifdef MSRV32_RF_BYPASS_EN
    chk("bypass_same_cycle", rs1, 32'h22);
`else
    chk("bypass_same_cycle", rs1, 32'h11);
`endif
    chk("same_addr_ports", rs2, rs1);
    @(posedge clk);
    m_regs[9] = 32'h22;
    m_cnt = m_cnt + 32'd1;
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("bypass_next_cycle", rs1, 32'h22);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] r_rd;
      logic [4:0] r_a1;
      logic [4:0] r_a2;
      r_rd = 5'($urandom_range(0, 31));
      r_a1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_a2 = ($urandom_range(0, 3) == 0) ? r_a1 : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), r_rd, $urandom, r_a1, r_a2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_reg_file.md
Name: msrv32_wb_reg_file

Overview:
- Writeback-side consumer of the WB mux result: the 32x32 integer register file that commits the selected writeback data to rd.
- Supplies rs1/rs2 operands to decode/execute.
- Adds a same-cycle write-to-read bypass, x0 hardwiring, flush gating, and a committed-write counter for debug/perf.
- Sits between the WB mux select unit (write side) and the operand path feeding the ALU second-source mux (read side).

Parameters:
- XLEN, 32, data width of each register and of the write/read data ports
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5
- CNT_W, 32, width of the committed-write counter

Ports:
- clk_in  input  1  single system clock; all state updates on the rising edge
- rst_in  input  1  reset, synchronous, active-high
- wr_en_in  input  1  writeback request for the current instruction
- flush_in  input  1  kill the current writeback (trap/branch flush); overrides wr_en_in
- rd_addr_in  input  5  destination register index
- rd_in  input  XLEN  writeback data (WB mux output)
- rs_1_addr_in  input  5  read port 1 index
- rs_2_addr_in  input  5  read port 2 index
- rs_1_out  output  XLEN  read port 1 data
- rs_2_out  output  XLEN  read port 2 data
- wr_count_out  output  CNT_W  number of committed writes to x1..x31

Behaviour:
- commit = wr_en_in & ~flush_in & ~rst_in & (rd_addr_in != 0).
- Write:
  - On the rising edge with commit=1, reg[rd_addr_in] <= rd_in.
  - Write latency is 1 cycle: the array holds the new value from the following cycle onward.
- Read:
  - Combinational, 0-cycle latency from the address to rs_x_out.
  - Index 0 always reads 0, regardless of any write attempt.
- Reset:
  - While rst_in=1 at a rising edge, all registers 1..31 <= 0 and wr_count_out <= 0.
  - Any concurrent write is dropped, so reset has priority over a write in flight.
  - rs_1_out and rs_2_out read 0 for every address during and after reset until a write occurs; bypass is disabled while rst_in=1.
- Counter:
  - wr_count_out increments by 1 on each edge with commit=1.
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
  - Writes to x0, flushed writes, and writes during reset do not count.
- Simultaneous events:
  - flush_in and wr_en_in both 1: no write, no count.
  - rs_1_addr_in == rs_2_addr_in: both ports return identical data.
  - A write and a read of the same index in the same cycle return the bypass value if enabled (see Optional Feature), otherwise the old value.
- No stall input: the upstream unit holds wr_en_in low when the stage is not valid.

Optional Feature:
- Macro MSRV32_RF_BYPASS_EN.
- Defined: if commit=1 and rs_x_addr_in == rd_addr_in, rs_x_out = rd_in in the same cycle (write-first).
- Undefined: rs_x_out always shows array contents (read-first); the new value becomes visible one cycle later.
- x0 and reset rules apply in both builds.

Decomposition:
- Shared package msrv32_pkg holds:
  - XLEN, NREGS, REG_ADDR_W=5
  - the WB select encodings WB_ALU=000, WB_LU=001, WB_IMM=010, WB_IADDER_OUT=011, WB_CSR=100, WB_PC_PLUS=101, so the mux and the register file use one definition
- One sub-module is natural: msrv32_rf_read_port, instantiated twice. It covers address decode, x0 zeroing, and the optional bypass compare.
- The array and the counter stay in the top module.

Test Plan:
- Reset: hold rst_in=1 for 2 cycles after preloading x5=0xDEADBEEF -> rs_1_out(addr 5)=0 and wr_count_out=0 after release.
- Basic write: wr_en=1, rd=3, rd_in=0x12345678 -> rs_2_out(addr 3)=0x12345678 on the next cycle; wr_count_out=1.
- x0 write: wr_en=1, rd=0, rd_in=0xFFFFFFFF -> rs_1_out(addr 0)=0; wr_count_out unchanged.
- Flush priority: wr_en=1, flush=1, rd=7, rd_in=0xA5A5A5A5 -> x7 keeps its prior value 0; count unchanged.
- Bypass: x9=0x11, then same-cycle write rd=9, rd_in=0x22 with rs_1_addr=9 -> rs_1_out=0x22 with MSRV32_RF_BYPASS_EN, 0x11 without; 0x22 in both builds the next cycle.
- Counter wrap and reset-over-write:
  - Force the count to 0xFFFFFFFF and commit one write -> wr_count_out=0.
  - Assert rst_in with wr_en=1, rd=4 -> x4=0 and count=0.
